// File: rtl/fifo_sync_prog.sv
// Synchronous FIFO with programmable almost flags, occupancy count, flush and FWFT/registered read; push->visible after 1 edge.
// No stall: rejected push on full / pop on empty change nothing and pulse a registered error flag the following cycle.
module fifo_sync_prog #(
    parameter int W_WIDTH   = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [W_WIDTH-1:0]         in_data,
    input  logic                       pop,
    output logic [W_WIDTH-1:0]         data_out,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       push_err_on_full,
    output logic                       pop_err_on_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    logic [W_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic               r_push_err;
    logic               r_pop_err;
    logic               w_pop_ok;
    logic               w_push_ok;

    // A pop frees a slot in the same cycle, so a full FIFO still takes a push alongside a valid pop.
    assign w_pop_ok  = pop && (r_count != '0);
    assign w_push_ok = push && ((r_count != DEPTH_C) || w_pop_ok);

    always_ff @(posedge clk) begin
        if (!rst && !flush && w_push_ok) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_push_err <= 1'b0;
            r_pop_err  <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop_ok && !w_push_ok) begin
                r_count <= r_count - 1'b1;
            end
            r_push_err <= push && !w_push_ok;
            r_pop_err  <= pop && !w_pop_ok;
        end
    end

    generate
        if (FWFT == 0) begin : g_reg_read
            logic [W_WIDTH-1:0] r_data_out;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_data_out <= '0;
                end else if (!flush && w_pop_ok) begin
                    r_data_out <= r_mem[r_rd_ptr];
                end
            end
            assign data_out = r_data_out;
        end else begin : g_fwft_read
            assign data_out = r_mem[r_rd_ptr];
        end
    endgenerate

    // Flags follow the registered count only, never the current-cycle requests.
    assign full             = (r_count == DEPTH_C);
    assign empty            = (r_count == '0);
    assign almost_full      = (r_count >= AF_C);
    assign almost_empty     = (r_count <= AE_C);
    assign count            = r_count;
    assign push_err_on_full = r_push_err;
    assign pop_err_on_empty = r_pop_err;

endmodule

// File: doc/fifo_sync_prog.md
# fifo_sync_prog

Parametrised synchronous FIFO for the FIFO verification environment, replacing the fixed-size design under test. It adds configurable depth, programmable almost-full/almost-empty thresholds, an occupancy count, a synchronous flush, and a selectable first-word-fall-through (FWFT) read mode. The push/pop/error-flag signalling of the existing FIFO is retained, so the current driver and monitor protocol carries over unchanged.

## Interface
- W_WIDTH, 8: data width in bits (≥1).
- DEPTH, 16: number of entries. Power of two, ≥2.
- AF_THRESH, DEPTH-2: almost_full asserts when count ≥ AF_THRESH. Range 1..DEPTH.
- AE_THRESH, 2: almost_empty asserts when count ≤ AE_THRESH. Range 0..DEPTH-1.
- FWFT, 0: read mode. 0 = standard registered read, 1 = first-word-fall-through.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  synchronous clear of contents.
- push  in  1  write request.
- in_data  in  W_WIDTH  write data.
- pop  in  1  read request.
- data_out  out  W_WIDTH  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_THRESH.
- almost_empty  out  1  count ≤ AE_THRESH.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- push_err_on_full  out  1  one-cycle pulse: a push was rejected.
- pop_err_on_empty  out  1  one-cycle pulse: a pop was rejected.

## Operation
- Storage: DEPTH × W_WIDTH array. wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Occupancy is held in the count register.
- Pop acceptance (pop_ok): pop && !empty.
- Push acceptance (push_ok): push && (!full || pop_ok). A push to a full FIFO is accepted when a valid pop occurs in the same cycle.
- Pop on empty with a simultaneous push: the pop is rejected and pop_err_on_empty pulses. The push is accepted. This applies in both modes.
- Accepted push: mem[wr_ptr] ← in_data, then wr_ptr++.
- Accepted pop: rd_ptr++.
- count update:
  - +1 on push_ok only.
  - −1 on pop_ok only.
  - Unchanged when both or neither occur.
- Rejected requests change no pointer, count or memory.
- Flags full, empty, almost_full and almost_empty are decoded combinationally from the count register only, never from the current-cycle inputs.
- Read path, FWFT=0:
  - data_out is a register.
  - On pop_ok it loads mem[rd_ptr] at the clock edge.
  - Otherwise it holds its value.
- Read path, FWFT=1:
  - data_out = mem[rd_ptr] (asynchronous read), so the head word is visible whenever !empty.
  - pop acknowledges the visible word.
  - data_out is don't-care when empty; the bench must not check it.
- Error flags: registered. Each asserts for exactly one cycle, the cycle after the rejected request, and is re-asserted on every consecutive rejected cycle.
- Priority, highest first: rst > flush > push/pop.
- Flush:
  - wr_ptr, rd_ptr and count are set to 0, and both error flags to 0.
  - Any push or pop in the same cycle is ignored, with no error pulse.
  - Memory contents are not cleared.
  - data_out holds (FWFT=0).

## Timing
- Reset values (cycle after rst sampled high): count 0, empty 1, almost_empty 1, full 0, almost_full 0, both error flags 0, data_out 0 (FWFT=0), pointers 0.
- Reset asserted mid-operation discards all contents on the next edge. This is identical to a flush, plus data_out ← 0.
- Write-to-read latency:
  - A word pushed at edge N sets empty=0 and count=1 after edge N.
  - FWFT=1: the word is visible on data_out after edge N.
  - FWFT=0: a pop in cycle N+1 presents the word on data_out after edge N+1.
- Flag latency: full, almost_full, etc. reflect an operation one cycle after the edge that performs it.
- Full FIFO with push+pop: count stays DEPTH and full stays 1. The oldest word is read and the new word is written at the freed slot.
- Empty FIFO with push+pop: count becomes 1 and pop_err_on_empty pulses.
- Sustained throughput: one push and one pop per cycle, with no bubbles.

## Test plan
- Fill and drain: rst, then push 0x01..0x10 (DEPTH=16) on consecutive cycles.
  - After the 16th push: full=1, count=16, almost_full has been 1 since count=14.
  - Pop 16 times: data_out sequence is 0x01..0x10, empty=1 at the end, almost_empty=1 once count ≤ 2.
- Overflow: with the FIFO full, push 0xAA for 2 cycles with no pop.
  - push_err_on_full pulses for 2 cycles, count stays 16.
  - The subsequent drain returns no 0xAA.
- Underflow and simultaneous push: with the FIFO empty, assert pop and push 0x55 together.
  - pop_err_on_empty=1 for one cycle, count=1.
  - The next pop returns 0x55.
- Full with push+pop: with the FIFO full of 0x01..0x10, push 0x77 and pop in the same cycle.
  - Pop returns 0x01, count stays 16, no error pulse.
  - The last word drained is 0x77.
- Pointer wrap: with DEPTH=4, run 10 cycles of interleaved push/pop of an incrementing pattern. Output order equals input order across the wrap.
- FWFT=1 plus flush:
  - Push 0x3C: data_out=0x3C on the next cycle without a pop.
  - Flush together with push: count=0, empty=1, no error pulse, and the pushed word is lost.
  - rst mid-fill gives all reset values.
